// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// master = word producer / serial consumer side, slave = the transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned N = 6
);
    logic         load;
    logic [N-1:0] pdata;
    logic         ready;
    logic         so;
    logic         so_valid;
    logic         done;

    modport master (
        output load,
        output pdata,
        input  ready,
        input  so,
        input  so_valid,
        input  done
    );

    modport slave (
        input  load,
        input  pdata,
        output ready,
        output so,
        output so_valid,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: one N-bit word per frame, MSB first, registered outputs.
// Define PIPO_PARITY_EN to append one even-parity bit to every frame.
module piso_shift_tx #(
    parameter int unsigned N = 6
) (
    input logic            clk,
    input logic            rst_n,
    piso_shift_tx_if.slave bus
);

    localparam int unsigned CntW = $clog2(N + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StShift  = 2'd1;
`ifdef PIPO_PARITY_EN
    localparam logic [1:0] StParity = 2'd2;
`endif

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            so_q, so_d;
    logic            so_valid_q, so_valid_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            last_bit;
`ifdef PIPO_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // cnt_q counts bits already on the line; N-1 means the final data bit is out now.
    assign last_bit = (cnt_q == CntW'(N - 1));

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
`ifdef PIPO_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.load && ready_q) begin
                    shreg_d    = bus.pdata;
                    cnt_d      = '0;
                    state_d    = StShift;
                    so_d       = bus.pdata[N-1];
                    so_valid_d = 1'b1;
                    ready_d    = 1'b0;
`ifdef PIPO_PARITY_EN
                    parity_d   = ^bus.pdata;
`endif
                end
            end
            StShift: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
`ifdef PIPO_PARITY_EN
                    state_d    = StParity;
                    so_d       = parity_q;
                    so_valid_d = 1'b1;
`else
                    state_d    = StIdle;
                    ready_d    = 1'b1;
                    done_d     = 1'b1;
`endif
                end else begin
                    // so_q already shows shreg_q[N-1]; the next bit down follows.
                    so_d       = shreg_q[N-2];
                    so_valid_d = 1'b1;
                end
            end
`ifdef PIPO_PARITY_EN
            StParity: begin
                state_d = StIdle;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef PIPO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
`ifdef PIPO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.ready    = ready_q;
    assign bus.so       = so_q;
    assign bus.so_valid = so_valid_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx with a bit-level scoreboard of expected serial output.
// Works in both builds; frame length follows PIPO_PARITY_EN.
module tb_piso_shift_tx;

    localparam int unsigned N = 6;
`ifdef PIPO_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic exp_q[$];

    piso_shift_tx_if #(.N(N)) bus ();

    piso_shift_tx #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PIPO_PARITY_EN
        exp_q.push_back(^w);
`endif
    endfunction

    task automatic chk_idle_regs(input string tag);
        chk({tag, "_ready"}, bus.ready, 1);
        chk({tag, "_so"}, bus.so, 0);
        chk({tag, "_so_valid"}, bus.so_valid, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    task automatic expect_bits(input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            chk("so_valid", bus.so_valid, 1);
            chk("ready_busy", bus.ready, 0);
            chk("so", bus.so, e);
        end
    endtask

    task automatic expect_done();
        @(negedge clk);
        chk("done", bus.done, 1);
        chk("ready_done", bus.ready, 1);
        chk("so_valid_done", bus.so_valid, 0);
    endtask

    task automatic start_word(input logic [N-1:0] w);
        bus.load  = 1'b1;
        bus.pdata = w;
        push_word(w);
    endtask

    // Full frame with load dropped after accept and X on the inputs while busy.
    task automatic simple_frame(input logic [N-1:0] w);
        @(negedge clk);
        start_word(w);
        expect_bits(1);
        bus.load  = 1'bx;
        bus.pdata = 'x;
        expect_bits(FL - 2);
        bus.load = 1'b0;
        expect_bits(1);
        expect_done();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        bus.load  = 1'b1;
        bus.pdata = 6'b101010;
        #1 rst_n = 1'b0;
        #1 chk_idle_regs("reset_async");
        repeat (2) begin
            @(negedge clk);
            chk_idle_regs("reset_hold");
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk_idle_regs("post_reset");

        simple_frame(6'b101010);
        simple_frame(6'b110000);

        // Load while busy: second word offered mid-frame must be dropped.
        @(negedge clk);
        start_word(6'b111000);
        expect_bits(1);
        bus.load = 1'b0;
        expect_bits(1);
        bus.load  = 1'b1;
        bus.pdata = 6'b000111;
        expect_bits(FL - 3);
        bus.load = 1'b0;
        expect_bits(1);
        expect_done();
        repeat (3) begin
            @(negedge clk);
            chk("busy_load_dropped", bus.so_valid, 0);
        end

        // Back-to-back with load held high through the done cycle.
        @(negedge clk);
        start_word(6'b100001);
        expect_bits(1);
        bus.pdata = 6'b011110;
        push_word(6'b011110);
        expect_bits(FL - 1);
        expect_done();
        expect_bits(1);
        bus.load  = 1'b0;
        bus.pdata = 'x;
        expect_bits(FL - 1);
        expect_done();

        // Reset during cycle 3 of a frame.
        @(negedge clk);
        start_word(6'b110101);
        expect_bits(1);
        bus.load = 1'b0;
        expect_bits(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_regs("reset_mid_frame");
        exp_q.delete();
        @(negedge clk);
        chk_idle_regs("reset_mid_hold");
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle_regs("after_abort");
        end
        simple_frame(6'b100110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in serial-out shift transmitter: accepts an N-bit word through a valid/ready load handshake and drives it out one bit per clock, MSB first, on a single serial line. It is the transmit end of the serial-in parallel-out shift register in the lab datapath, and its `so` output connects directly to that receiver's serial input. Registered outputs, one frame in flight at a time, optional trailing parity bit.

## Interface
- `N`, default 6: word width in bits; legal range 2 to 32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load` input 1: word-valid from the producer; sampled on the rising edge of `clk`.
- `pdata` input N: parallel word, captured when `load && ready`.
- `ready` output 1: high when the block can accept a word (IDLE only).
- `so` output 1: serial data out.
- `so_valid` output 1: high in each cycle in which `so` carries a frame bit.
- `done` output 1: one-cycle pulse marking the end of a frame.

## Operation
- **Reset values.** While `rst_n` is low, all of the following hold immediately, without waiting for a clock edge:
  - state = IDLE
  - `ready` = 1, `so` = 0, `so_valid` = 0, `done` = 0
  - shift register = 0, bit counter = 0
- **States:** IDLE, SHIFT, and PARITY (PARITY exists only when `PIPO_PARITY_EN` is defined).
- **IDLE:**
  - `ready` = 1, `so` = 0, `so_valid` = 0.
  - On `load && ready`: capture `pdata` into the shift register, clear the counter, go to SHIFT.
- **SHIFT:**
  - `so` = shift register bit N-1; `so_valid` = 1; `ready` = 0.
  - Each clock: shift left by one, fill the LSB with 0, increment the counter.
  - After the N-th bit has been presented: go to PARITY if enabled, otherwise go to IDLE and pulse `done`.
- **PARITY:**
  - For one cycle: `so` = even-parity bit (XOR of the captured word), `so_valid` = 1.
  - Then go to IDLE and pulse `done`.
- **Counter:** width is $clog2(N+1); it never wraps inside a frame.
- **Load while busy:** `load` is ignored while `ready` = 0. The word is not queued and the in-flight frame is unaffected.
- **`done` timing:** `done` is high for exactly one cycle, namely the first IDLE cycle after the frame. In that cycle `ready` = 1 as well, so a `load` in that cycle is accepted.
- **`pdata` stability:** `pdata` is only sampled at the accept edge. Later changes to `pdata` have no effect on the frame.
- **X on `load` or `pdata` while busy:** must not disturb `so`.

## Timing
- **Accept:** let edge E0 be the edge where `load && ready`. Bit N-1 appears on `so` in the cycle after E0, i.e. cycle 1.
- **Data bits:** bit k appears in cycle N-k, so bit 0 is in cycle N.
- **Without parity:** `done` = 1 and `ready` = 1 in cycle N+1. Throughput is one word per N+1 cycles.
- **With parity:** the parity bit is in cycle N+1; `done` and `ready` are in cycle N+2.
- **Back-to-back frames:** with `load` held high, the MSB of the next word appears in cycle N+2 (no parity). There is exactly one idle gap cycle with `so_valid` = 0.
- **Reset mid-frame:** abort immediately, return to the reset values, and do not pulse `done`. The first edge after `rst_n` rises behaves as IDLE.

## Configuration
- `PIPO_PARITY_EN`
  - **Defined:** the PARITY state is compiled in and one even-parity bit is appended to each frame. Frame length is N+1 bits; `done` arrives at cycle N+2.
  - **Undefined:** no PARITY state and no parity logic. Frame length is N bits; `done` arrives at cycle N+1.
- The port list is identical in both builds.

## Test plan
- **Reset:** N=6, hold `rst_n` low for 2 cycles with `load` = 1.
  - `ready` = 1, `so` = 0, `so_valid` = 0, `done` = 0 throughout.
  - No frame starts until `rst_n` goes high.
- **Basic frame:** load `pdata` = 6'b101010, no parity.
  - `so` = 1,0,1,0,1,0 in cycles 1–6 with `so_valid` = 1.
  - Cycle 7: `done` = 1, `ready` = 1, `so_valid` = 0.
- **Parity build:** `PIPO_PARITY_EN` defined, load 6'b101010.
  - Same 6 data bits, then `so` = 1 in cycle 7 (three ones, so parity = 1).
  - `done` in cycle 8.
  - Repeat with 6'b110000: parity bit = 0.
- **Load while busy:** load 6'b111000, then at cycle 3 assert `load` with `pdata` = 6'b000111.
  - Output stays 1,1,1,0,0,0.
  - The second word is never transmitted unless `load` is still asserted in cycle 7.
- **Back-to-back:** hold `load` = 1 with 6'b100001 then 6'b011110.
  - Cycles 1–6: 1,0,0,0,0,1.
  - Cycle 7: `done`, `so_valid` = 0.
  - Cycles 8–13: 0,1,1,1,1,0.
- **Reset mid-frame:** pull `rst_n` low during cycle 3 of a frame.
  - Outputs go to reset values before the next edge.
  - No `done` pulse.
  - A new load after release transmits correctly from the MSB.
